// File: rtl/fp_mul.sv
// Sequential IEEE-754 binary32 multiplier: 24-cycle shift-add significand multiply,
// one-cycle round/pack, registered result with a one-cycle done pulse.
module fp_mul #(
   parameter int unsigned W = 32,
   parameter int unsigned M = 22,
   parameter int unsigned E = 30
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         act,
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in2,
   input  logic [2:0]   round_m,
   output logic [W-1:0] out,
   output logic         ov,
   output logic         un,
   output logic         inv,
   output logic         inexact,
   output logic         done,
   output logic         busy
);

   localparam int unsigned FW   = M + 1;
   localparam int unsigned EW   = E - M;
   localparam int unsigned SW   = FW + 1;
   localparam int unsigned PW   = 2 * SW;
   localparam int unsigned XW   = EW + 2;
   localparam int unsigned CW   = $clog2(SW);
   localparam int unsigned BIAS = (1 << (EW - 1)) - 1;
   localparam int unsigned EMAX = (1 << EW) - 1;

   localparam logic signed [XW-1:0] X_BIAS = XW'(BIAS);
   localparam logic signed [XW-1:0] X_EMAX = XW'(EMAX);
   localparam logic signed [XW-1:0] X_ZERO = XW'(0);

   localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
   localparam logic [W-1:0] INF  = {1'b0, {EW{1'b1}}, {FW{1'b0}}};
   localparam logic [W-1:0] MAXF = {1'b0, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RD  = 3'd2;
   localparam logic [2:0] RM_RU  = 3'd3;
   localparam logic [2:0] RM_RNA = 3'd4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]    r_state, w_state_nxt;
   logic [PW-1:0] r_a, r_prod;
   logic [SW-1:0] r_b;
   logic [CW-1:0] r_cnt;
   logic [EW-1:0] r_e1, r_e2;
   logic          r_sign;
   logic [2:0]    r_rm;
   logic [W-1:0]  r_res;
   logic          r_res_ov, r_res_un, r_res_inv, r_res_nx;

   // operand classification on the live inputs, used only at acceptance
   logic [EW-1:0] w_e1, w_e2;
   logic [FW-1:0] w_f1, w_f2;
   logic          w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2;
   logic          w_special, w_sgn_in, w_spec_inv;
   logic [W-1:0]  w_spec_out;

   assign w_e1       = in1[E:M+1];
   assign w_e2       = in2[E:M+1];
   assign w_f1       = in1[M:0];
   assign w_f2       = in2[M:0];
   assign w_nan1     = (w_e1 == EW'(EMAX)) && (w_f1 != '0);
   assign w_nan2     = (w_e2 == EW'(EMAX)) && (w_f2 != '0);
   assign w_inf1     = (w_e1 == EW'(EMAX)) && (w_f1 == '0);
   assign w_inf2     = (w_e2 == EW'(EMAX)) && (w_f2 == '0);
   assign w_zero1    = (w_e1 == '0);
   assign w_zero2    = (w_e2 == '0);
   assign w_special  = w_nan1 | w_nan2 | w_inf1 | w_inf2 | w_zero1 | w_zero2;
   assign w_sgn_in   = in1[W-1] ^ in2[W-1];
   assign w_spec_inv = w_nan1 | w_nan2 | (w_zero1 & w_inf2) | (w_inf1 & w_zero2);
   assign w_spec_out = w_spec_inv      ? QNAN :
                       (w_inf1 | w_inf2) ? (INF | {w_sgn_in, (W-1)'(0)}) :
                       {w_sgn_in, (W-1)'(0)};

   // normalize, round and pack from the finished product
   logic                 w_norm, w_guard, w_sticky, w_inc, w_carry, w_ovf, w_unf;
   logic signed [XW-1:0] w_exp, w_exp_fin;
   logic [SW-1:0]        w_sig;
   logic [SW:0]          w_sig_rnd;
   logic [FW-1:0]        w_frac_fin;
   logic [W-1:0]         w_sgn_mask, w_ovf_out;

   assign w_norm     = r_prod[PW-1];
   assign w_exp      = $signed(XW'(r_e1)) + $signed(XW'(r_e2)) - X_BIAS + $signed(XW'(w_norm));
   assign w_sig      = w_norm ? r_prod[PW-1 -: SW] : r_prod[PW-2 -: SW];
   assign w_guard    = w_norm ? r_prod[PW-SW-1] : r_prod[PW-SW-2];
   assign w_sticky   = w_norm ? (|r_prod[PW-SW-2:0]) : (|r_prod[PW-SW-3:0]);
   assign w_sgn_mask = {r_sign, (W-1)'(0)};
   assign w_sig_rnd  = {1'b0, w_sig} + (SW+1)'(w_inc);
   assign w_carry    = w_sig_rnd[SW];
   assign w_exp_fin  = w_exp + $signed(XW'(w_carry));
   assign w_frac_fin = w_carry ? w_sig_rnd[SW-1:1] : w_sig_rnd[FW-1:0];
   assign w_ovf      = (w_exp_fin >= X_EMAX);
   assign w_unf      = (w_exp_fin <= X_ZERO);

   // rounding increment and overflow result per mode; other codes truncate
   always_comb begin
      w_inc     = 1'b0;
      w_ovf_out = MAXF | w_sgn_mask;
      case (r_rm)
         RM_RNE: begin
            w_inc     = w_guard & (w_sticky | w_sig[0]);
            w_ovf_out = INF | w_sgn_mask;
         end
         RM_RNA: begin
            w_inc     = w_guard;
            w_ovf_out = INF | w_sgn_mask;
         end
         RM_RU: begin
            w_inc     = ~r_sign & (w_guard | w_sticky);
            w_ovf_out = r_sign ? (MAXF | w_sgn_mask) : INF;
         end
         RM_RD: begin
            w_inc     = r_sign & (w_guard | w_sticky);
            w_ovf_out = r_sign ? (INF | w_sgn_mask) : MAXF;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (act) w_state_nxt = w_special ? S_FIN : S_CALC;
         S_CALC:  if (r_cnt == CW'(SW-1)) w_state_nxt = S_ROUND;
         S_ROUND: w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_prod    <= '0;
         r_cnt     <= '0;
         r_e1      <= '0;
         r_e2      <= '0;
         r_sign    <= 1'b0;
         r_rm      <= '0;
         r_res     <= '0;
         r_res_ov  <= 1'b0;
         r_res_un  <= 1'b0;
         r_res_inv <= 1'b0;
         r_res_nx  <= 1'b0;
         out       <= '0;
         ov        <= 1'b0;
         un        <= 1'b0;
         inv       <= 1'b0;
         inexact   <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done <= (r_state == S_FIN);
         busy <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: if (act) begin
               r_a       <= PW'({1'b1, w_f1});
               r_b       <= {1'b1, w_f2};
               r_prod    <= '0;
               r_cnt     <= '0;
               r_e1      <= w_e1;
               r_e2      <= w_e2;
               r_sign    <= w_sgn_in;
               r_rm      <= round_m;
               r_res     <= w_spec_out;
               r_res_ov  <= 1'b0;
               r_res_un  <= 1'b0;
               r_res_inv <= w_spec_inv;
               r_res_nx  <= 1'b0;
               ov        <= 1'b0;
               un        <= 1'b0;
               inv       <= 1'b0;
               inexact   <= 1'b0;
            end
            S_CALC: begin
               if (r_b[0]) r_prod <= r_prod + r_a;
               r_a   <= r_a << 1;
               r_b   <= r_b >> 1;
               r_cnt <= r_cnt + CW'(1);
            end
            S_ROUND: begin
               r_res_inv <= 1'b0;
               if (w_ovf) begin
                  r_res    <= w_ovf_out;
                  r_res_ov <= 1'b1;
                  r_res_un <= 1'b0;
                  r_res_nx <= 1'b1;
               end else if (w_unf) begin
                  r_res    <= w_sgn_mask;
                  r_res_ov <= 1'b0;
                  r_res_un <= 1'b1;
                  r_res_nx <= 1'b1;
               end else begin
                  r_res    <= {r_sign, w_exp_fin[EW-1:0], w_frac_fin};
                  r_res_ov <= 1'b0;
                  r_res_un <= 1'b0;
                  r_res_nx <= w_guard | w_sticky;
               end
            end
            S_FIN: begin
               out     <= r_res;
               ov      <= r_res_ov;
               un      <= r_res_un;
               inv     <= r_res_inv;
               inexact <= r_res_nx;
            end
            default: ;
         endcase
      end
   end

endmodule
